// File: rtl/demux_stream_1ton.sv
// Registered 1-to-N stream demultiplexer: one holding register per output channel,
// routed by in_sel or round-robin, with a saturating counter of dropped words.
module demux_stream_1ton #(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  parameter int MODE  = 0,
  parameter int CNT_W = 8,
  localparam int SEL_W = (N <= 2) ? 1 : $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [N*WIDTH-1:0]   out_data,
  output logic [N-1:0]         out_valid,
  input  logic [N-1:0]         out_ready,
  output logic [SEL_W-1:0]     rr_ptr,
  output logic [CNT_W-1:0]     drop_cnt
);

  // Handshake: a word moves on a side when its valid and ready are both high at the
  // rising edge. in_ready depends combinationally on out_ready of the target slot, so
  // a slot that drains this edge can be reloaded on the same edge.

  logic [N-1:0][WIDTH-1:0] r_data;
  logic [N-1:0]            r_valid;
  logic [CNT_W-1:0]        r_drop;
  logic [SEL_W-1:0]        r_rr_ptr;

  logic [SEL_W-1:0]        w_tgt;
  logic [N-1:0]            w_hit;
  logic [N-1:0]            w_free;
  logic [N-1:0]            w_load;
  logic                    w_tgt_ok;
  logic                    w_accept;

  always_comb begin
    w_hit = '0;
    for (int k = 0; k < N; k++) begin
      w_hit[k] = (w_tgt == SEL_W'(k));
    end
  end

  // An out-of-range target matches no slot; it is accepted and counted as a drop.
  assign w_tgt_ok = |w_hit;
  assign w_free   = ~r_valid | out_ready;
  assign in_ready = w_tgt_ok ? |(w_hit & w_free) : 1'b1;
  assign w_accept = in_valid & in_ready;
  assign w_load   = w_accept ? w_hit : '0;

  generate
    if (MODE == 1) begin : g_rr
      assign w_tgt = r_rr_ptr;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_rr_ptr <= '0;
        end else if (w_accept) begin
          r_rr_ptr <= (r_rr_ptr == SEL_W'(N - 1)) ? '0 : r_rr_ptr + SEL_W'(1);
        end
      end
    end else begin : g_sel
      assign w_tgt    = in_sel;
      assign r_rr_ptr = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= '0;
      r_drop  <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (w_load[k]) begin
          r_data[k]  <= in_data;
          r_valid[k] <= 1'b1;
        end else if (out_ready[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
      if (w_accept && !w_tgt_ok && (r_drop != '1)) begin
        r_drop <= r_drop + CNT_W'(1);
      end
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign rr_ptr    = r_rr_ptr;
  assign drop_cnt  = r_drop;

endmodule
